lipsi_program_loader: RTL

Serial boot loader sitting directly upstream of the Lipsi processor core. It receives a framed program image over a UART line, writes it byte-by-byte into the processor's 256×8 instruction memory, and holds the core in reset until a complete, checksum-valid image has been stored. It replaces the fixed power-on program image with a downloadable one.

---
 rtl/lipsi_program_loader_if.sv | 30 +++
 rtl/lipsi_program_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lipsi_program_loader_if.sv
// Boot-loader pin bundle: UART receive line in, instruction-memory write port and core control out.
interface lipsi_program_loader_if;
    logic       rxd;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;

    modport master (
        input  rxd,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output cpu_hold,
        output load_done,
        output load_err
    );

    modport slave (
        output rxd,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  cpu_hold,
        input  load_done,
        input  load_err
    );
endinterface

// File: rtl/lipsi_program_loader.sv
// UART boot loader: receives A5/LEN/data/CHK frames and writes data into the Lipsi instruction memory.
// Latency: memory write lands one cycle after the stop-bit sample; no backpressure, the UART line cannot be stalled.
module lipsi_program_loader #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                    clk,
    input  logic                    reset,
    lipsi_program_loader_if.master  bus
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        WAIT_SYNC, GET_LEN, GET_DATA, GET_CHK, DONE, ERROR
    } pr_state_t;

    logic            rxd_meta_q, rxd_sync_q, rxd_prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_ferr_q, rx_ferr_d;

    pr_state_t       pr_state_q, pr_state_d;
    logic [8:0]      remain_q, remain_d;
    logic [7:0]      sum_q, sum_d;
    logic [7:0]      next_addr_q, next_addr_d;
    logic            mem_we_q, mem_we_d;
    logic [7:0]      mem_addr_q, mem_addr_d;
    logic [7:0]      mem_wdata_q, mem_wdata_d;

    // Synchronizer and previous-sample flop idle high so reset never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= bus.rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rxd_prev_q && !rxd_sync_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                    bit_d      = '0;
                end
            end
            RX_START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d      = '0;
                    rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rxd_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d      = '0;
                    rx_valid_d = rxd_sync_q;
                    rx_ferr_d  = !rxd_sync_q;
                    rx_state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pr_state_q  <= WAIT_SYNC;
            remain_q    <= '0;
            sum_q       <= '0;
            next_addr_q <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            pr_state_q  <= pr_state_d;
            remain_q    <= remain_d;
            sum_q       <= sum_d;
            next_addr_q <= next_addr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        pr_state_d  = pr_state_q;
        remain_d    = remain_q;
        sum_d       = sum_q;
        next_addr_d = next_addr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (rx_ferr_q) begin
            if (pr_state_q != DONE) begin
                pr_state_d = ERROR;
            end
        end else if (rx_valid_q) begin
            unique case (pr_state_q)
                WAIT_SYNC: begin
                    if (shift_q == 8'hA5) pr_state_d = GET_LEN;
                end
                GET_LEN: begin
                    // LEN of zero encodes a full 256-byte image.
                    remain_d    = {(shift_q == 8'h00), shift_q};
                    sum_d       = shift_q;
                    next_addr_d = '0;
                    pr_state_d  = GET_DATA;
                end
                GET_DATA: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = next_addr_q;
                    mem_wdata_d = shift_q;
                    sum_d       = sum_q + shift_q;
                    next_addr_d = next_addr_q + 1'b1;
                    remain_d    = remain_q - 1'b1;
                    if (remain_q == 9'd1) pr_state_d = GET_CHK;
                end
                GET_CHK: begin
                    pr_state_d = (shift_q == sum_q) ? DONE : ERROR;
                end
                DONE: begin
                    pr_state_d = DONE;
                end
                ERROR: begin
                    if (shift_q == 8'hA5) pr_state_d = GET_LEN;
                end
                default: pr_state_d = WAIT_SYNC;
            endcase
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_hold  = (pr_state_q != DONE);
    assign bus.load_done = (pr_state_q == DONE);
    assign bus.load_err  = (pr_state_q == ERROR);
endmodule
